cart_loader: RTL and testbench
==============================

CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 SHALL have no parameters; sizes are fixed to NROM: PRG 16 KiB or 32 KiB, CHR 8 KiB.
REQ-002 SHALL have ports: clk_sys  in  1  system clock; sole clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have ports: start  in  1  one-cycle pulse that begins a load.
REQ-005 SHALL have ports: in_data  in  8  iNES file byte; in_valid  in  1  byte present; in_ready  out  1  loader accepts.
REQ-006 SHALL have ports: prg_we  out  1; prg_a  out  15; prg_d  out  8  PRG memory write port.
REQ-007 SHALL have ports: chr_we  out  1; chr_a  out  13; chr_d  out  8  CHR memory write port.
REQ-008 SHALL have ports: mirror_v  out  1  header byte 6 bit 0 (1 = vertical mirroring).
REQ-009 SHALL have ports: prg_16k  out  1  header byte 4 == 1.
REQ-010 SHALL have ports: busy  out  1; done  out  1; err  out  1; nes_rst  out  1  holds the console in reset.

Function
REQ-011 SHALL implement states IDLE, HEADER, PRG, CHR, DONE, ERROR.
REQ-012 A byte SHALL be accepted when in_valid and in_ready are both 1 on a clk_sys edge.
REQ-013 in_ready SHALL be 1 only in HEADER, PRG and CHR; busy SHALL equal in_ready.
REQ-014 start SHALL be honoured in IDLE, DONE and ERROR: next state HEADER, byte counter cleared, done and err cleared, nes_rst set. start SHALL be ignored in other states.
REQ-015 HEADER SHALL accept 16 bytes, indexed 0-15.
REQ-016 Bytes 0-3 SHALL equal 0x4E, 0x45, 0x53, 0x1A.
REQ-017 Byte 4 SHALL be 1 or 2; byte 5 SHALL be 1.
REQ-018 In byte 6, bit 2 (trainer) SHALL be 0 and bits 7:4 SHALL be 0; in byte 7, bits 7:4 SHALL be 0.
REQ-019 Bytes 8-15 SHALL be ignored.
REQ-020 Any header check failure SHALL move the FSM to ERROR on the edge that accepts the offending byte; no further bytes SHALL be accepted.
REQ-021 mirror_v and prg_16k SHALL be registered when bytes 6 and 4 are accepted, and SHALL hold until the next accepted byte 6 and byte 4.
REQ-022 After byte 15, the FSM SHALL enter PRG.
REQ-023 In PRG, the k-th accepted byte (k from 0) SHALL produce exactly one cycle with prg_we=1, prg_a=k, prg_d=byte, on the cycle after acceptance.
REQ-024 PRG SHALL end after 16384 bytes if prg_16k is 1, otherwise after 32768 bytes, then enter CHR.
REQ-025 In CHR, the same one-cycle write rule SHALL apply on chr_we/chr_a/chr_d; CHR SHALL end after 8192 bytes and enter DONE.
REQ-026 prg_we and chr_we SHALL never both be 1 in the same cycle. When a write strobe is 0, its address/data outputs SHALL hold their last value.
REQ-027 Byte counters SHALL be 15 bits for PRG and 13 bits for CHR, and SHALL wrap to 0 on each state change. The last-byte compare SHALL use count == size-1 at acceptance.
REQ-028 done SHALL be 1 only in DONE; err SHALL be 1 only in ERROR.
REQ-029 nes_rst SHALL be 0 only in DONE.
REQ-030 Data bytes received after DONE SHALL NOT be accepted (in_ready=0).
REQ-031 A start pulse during HEADER/PRG/CHR SHALL NOT abort the load; rst is the only abort.

Reset
REQ-032 On rst: state IDLE; counters 0; prg_we=0, chr_we=0, prg_a=0, chr_a=0, prg_d=0, chr_d=0; mirror_v=0, prg_16k=0; in_ready=0, busy=0, done=0, err=0, nes_rst=1.
REQ-033 rst mid-load SHALL take effect on the same edge, and any pending write strobe SHALL be suppressed.

Structure
REQ-034 Package cart_loader_pkg SHALL hold the state enum, the four magic-byte constants, and the constants PRG_16K_BYTES=16384, PRG_32K_BYTES=32768, CHR_8K_BYTES=8192, HEADER_BYTES=16.
REQ-035 Header checks SHALL be a combinational sub-module ines_header_check with inputs (byte index, byte) and output (fail).

Verification
REQ-036 Valid 32K image: header 4E 45 53 1A 02 01 01 00 + 8×00, then 32768 PRG + 8192 CHR bytes. Required: 32768 prg_we pulses with prg_a 0..0x7FFF; then 8192 chr_we pulses; mirror_v=1, prg_16k=0, done=1, nes_rst=0.
REQ-037 16K image (byte 4 = 01): CHR writes start after exactly 16384 PRG writes, last prg_a=0x3FFF, and prg_16k=1.
REQ-038 Byte 3 = 0x1B: err=1 on the edge after that byte is accepted, in_ready=0, and zero write strobes.
REQ-039 Byte 6 = 0x10 (mapper 1): ERROR. A following start, then a valid image, SHALL clear err and finish in DONE.
REQ-040 in_valid toggled pseudo-randomly at 50% duty: write count and addresses SHALL be identical to the continuous-stream case.
REQ-041 rst asserted after 100 PRG bytes: on the next cycle, state IDLE, prg_we=0, nes_rst=1; a fresh start then loads from prg_a=0.

Source files
------------

// File: rtl/cart_loader_pkg.sv
// cart_loader_pkg: shared state encoding, iNES magic bytes and NROM image sizes.
package cart_loader_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, PRG, CHR, DONE, ERROR} state_e;
  localparam logic [7:0] MAGIC0 = 8'h4E;
  localparam logic [7:0] MAGIC1 = 8'h45;
  localparam logic [7:0] MAGIC2 = 8'h53;
  localparam logic [7:0] MAGIC3 = 8'h1A;
  localparam int unsigned PRG_16K_BYTES = 16384;
  localparam int unsigned PRG_32K_BYTES = 32768;
  localparam int unsigned CHR_8K_BYTES  = 8192;
  localparam int unsigned HEADER_BYTES  = 16;
  localparam logic [14:0] PRG_16K_LAST = 15'(PRG_16K_BYTES - 1);
  localparam logic [14:0] PRG_32K_LAST = 15'(PRG_32K_BYTES - 1);
  localparam logic [12:0] CHR_LAST     = 13'(CHR_8K_BYTES - 1);
  localparam logic [3:0]  HDR_LAST     = 4'(HEADER_BYTES - 1);
endpackage

// File: rtl/cart_loader_header.sv
// ines_header_check: flags a header byte that an NROM-only loader cannot accept.
module ines_header_check
  import cart_loader_pkg::*;
(
  input  logic [3:0] idx_i,
  input  logic [7:0] byte_i,
  output logic       fail_o
);
  always_comb begin
    fail_o = 1'b0;
    case (idx_i)
      4'd0: fail_o = byte_i != MAGIC0;
      4'd1: fail_o = byte_i != MAGIC1;
      4'd2: fail_o = byte_i != MAGIC2;
      4'd3: fail_o = byte_i != MAGIC3;
      4'd4: fail_o = byte_i != 8'd1 && byte_i != 8'd2;
      4'd5: fail_o = byte_i != 8'd1;
      // trainer bit and mapper low nibble must both be clear
      4'd6: fail_o = byte_i[2] || |byte_i[7:4];
      4'd7: fail_o = |byte_i[7:4];
      default: fail_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/cart_loader.sv
// cart_loader: streams an iNES NROM image into PRG/CHR memories and holds the console in reset until done.
module cart_loader
  import cart_loader_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        prg_we,
  output logic [14:0] prg_a,
  output logic [7:0]  prg_d,
  output logic        chr_we,
  output logic [12:0] chr_a,
  output logic [7:0]  chr_d,
  output logic        mirror_v,
  output logic        prg_16k,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        nes_rst
);
  state_e      state_q, state_d;
  logic [3:0]  hdr_q, hdr_d;
  logic [14:0] prg_cnt_q, prg_cnt_d;
  logic [12:0] chr_cnt_q, chr_cnt_d;
  logic        mirror_q, mirror_d, p16_q, p16_d;
  logic        prg_we_q, prg_we_d, chr_we_q, chr_we_d;
  logic [14:0] prg_a_q, prg_a_d;
  logic [12:0] chr_a_q, chr_a_d;
  logic [7:0]  prg_dat_q, prg_dat_d, chr_dat_q, chr_dat_d;
  logic        acc, hdr_fail, prg_last, chr_last;

  ines_header_check u_hdr (.idx_i(hdr_q), .byte_i(in_data), .fail_o(hdr_fail));

  assign in_ready = state_q inside {HEADER, PRG, CHR};
  assign acc      = in_valid && in_ready;
  assign prg_last = prg_cnt_q == (p16_q ? PRG_16K_LAST : PRG_32K_LAST);
  assign chr_last = chr_cnt_q == CHR_LAST;

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    prg_cnt_d = prg_cnt_q;
    chr_cnt_d = chr_cnt_q;
    mirror_d  = mirror_q;
    p16_d     = p16_q;
    prg_we_d  = 1'b0;
    prg_a_d   = prg_a_q;
    prg_dat_d = prg_dat_q;
    chr_we_d  = 1'b0;
    chr_a_d   = chr_a_q;
    chr_dat_d = chr_dat_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d   = HEADER;
          hdr_d     = '0;
          prg_cnt_d = '0;
          chr_cnt_d = '0;
        end
      end
      HEADER: begin
        if (acc) begin
          hdr_d    = hdr_q + 4'd1;
          mirror_d = hdr_q == 4'd6 ? in_data[0] : mirror_q;
          p16_d    = hdr_q == 4'd4 ? in_data == 8'd1 : p16_q;
          state_d  = hdr_fail ? ERROR : hdr_q == HDR_LAST ? PRG : HEADER;
        end
      end
      PRG: begin
        if (acc) begin
          prg_we_d  = 1'b1;
          prg_a_d   = prg_cnt_q;
          prg_dat_d = in_data;
          prg_cnt_d = prg_last ? '0 : prg_cnt_q + 15'd1;
          state_d   = prg_last ? CHR : PRG;
        end
      end
      CHR: begin
        if (acc) begin
          chr_we_d  = 1'b1;
          chr_a_d   = chr_cnt_q;
          chr_dat_d = in_data;
          chr_cnt_d = chr_last ? '0 : chr_cnt_q + 13'd1;
          state_d   = chr_last ? DONE : CHR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= IDLE;
      hdr_q     <= '0;
      prg_cnt_q <= '0;
      chr_cnt_q <= '0;
      mirror_q  <= 1'b0;
      p16_q     <= 1'b0;
      prg_we_q  <= 1'b0;
      prg_a_q   <= '0;
      prg_dat_q <= '0;
      chr_we_q  <= 1'b0;
      chr_a_q   <= '0;
      chr_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      prg_cnt_q <= prg_cnt_d;
      chr_cnt_q <= chr_cnt_d;
      mirror_q  <= mirror_d;
      p16_q     <= p16_d;
      prg_we_q  <= prg_we_d;
      prg_a_q   <= prg_a_d;
      prg_dat_q <= prg_dat_d;
      chr_we_q  <= chr_we_d;
      chr_a_q   <= chr_a_d;
      chr_dat_q <= chr_dat_d;
    end
  end

  assign prg_we   = prg_we_q;
  assign prg_a    = prg_a_q;
  assign prg_d    = prg_dat_q;
  assign chr_we   = chr_we_q;
  assign chr_a    = chr_a_q;
  assign chr_d    = chr_dat_q;
  assign mirror_v = mirror_q;
  assign prg_16k  = p16_q;
  assign busy     = in_ready;
  assign done     = state_q == DONE;
  assign err      = state_q == ERROR;
  assign nes_rst  = state_q != DONE;
endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: drives random iNES images and compares every memory write against the image contents.
module tb_cart_loader;
  logic        clk_sys = 1'b0, rst, start, in_valid, in_ready;
  logic [7:0]  in_data, prg_d, chr_d;
  logic        prg_we, chr_we, mirror_v, prg_16k, busy, done, err, nes_rst;
  logic [14:0] prg_a;
  logic [12:0] chr_a;
  int errors = 0, checks = 0;
  logic [7:0] img [0:40975];
  int psize = 32768;
  logic mon_clr;
  int prg_n, chr_n, bad_n, both_n, prg_at_chr;
  logic [14:0] last_prg_a;

  cart_loader dut (
    .clk_sys(clk_sys), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .prg_we(prg_we), .prg_a(prg_a), .prg_d(prg_d), .chr_we(chr_we),
    .chr_a(chr_a), .chr_d(chr_d), .mirror_v(mirror_v), .prg_16k(prg_16k), .busy(busy),
    .done(done), .err(err), .nes_rst(nes_rst)
  );

  always #5 clk_sys = ~clk_sys;

  // Write k of a phase must land at address k with image byte k of that phase.
  always @(posedge clk_sys) begin
    #1;
    if (mon_clr) begin
      prg_n = 0; chr_n = 0; bad_n = 0; both_n = 0; prg_at_chr = -1; last_prg_a = '0;
    end else begin
      if (prg_we && chr_we) both_n++;
      if (prg_we) begin
        if (prg_n >= psize || prg_a !== 15'(prg_n) || prg_d !== img[16 + prg_n]) bad_n++;
        last_prg_a = prg_a;
        prg_n++;
      end
      if (chr_we) begin
        if (prg_at_chr < 0) prg_at_chr = prg_n;
        if (chr_n >= 8192 || chr_a !== 13'(chr_n) || chr_d !== img[16 + psize + chr_n]) bad_n++;
        chr_n++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0 ] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make_img(input bit p16, input logic [7:0] b3, input logic [7:0] b6);
    psize = p16 ? 16384 : 32768;
    img[0] = 8'h4E; img[1] = 8'h45; img[2] = 8'h53; img[3] = b3;
    img[4] = p16 ? 8'd1 : 8'd2; img[5] = 8'd1; img[6] = b6; img[7] = 8'd0;
    for (int i = 8; i < 16; i++) img[i] = 8'd0;
    for (int i = 16; i < 16 + psize + 8192; i++) img[i] = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b, input bit gap, output bit ok);
    ok = 1'b0;
    if (gap && $urandom_range(1, 0) == 1) begin
      in_valid = 1'b0;
      @(negedge clk_sys);
    end
    in_data = b;
    in_valid = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk_sys);
        break;
      end
      @(negedge clk_sys);
    end
  endtask

  task automatic send_img(input int n, input bit gap, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n && ok; i++) begin
      start = i == 5000;
      send(img[i], gap, ok);
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    mon_clr = 1'b1;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    mon_clr = 1'b0;
  endtask

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mon_clr = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_nes_rst", nes_rst, 1);
    chk("rst_we", {prg_we, chr_we}, 0);
    chk("rst_addr", {prg_a, chr_a, prg_d, chr_d}, 0);
    chk("rst_flags", {mirror_v, prg_16k}, 0);
    rst = 1'b0;
    @(negedge clk_sys);

    // 32K image, continuous stream, with an ignored start pulse mid-PRG
    make_img(1'b0, 8'h1A, 8'h01);
    pulse_start();
    chk("load_busy", busy, 1);
    chk("load_nes_rst", nes_rst, 1);
    send_img(16 + 32768 + 8192, 1'b0, ok);
    chk("p32_accept", ok, 1);
    repeat (3) @(negedge clk_sys);
    chk("p32_prg_n", prg_n, 32768);
    chk("p32_chr_n", chr_n, 8192);
    chk("p32_prg_at_chr", prg_at_chr, 32768);
    chk("p32_last_prg_a", last_prg_a, 15'h7FFF);
    chk("p32_bad", bad_n, 0);
    chk("p32_both", both_n, 0);
    chk("p32_flags", {mirror_v, prg_16k}, 2'b10);
    chk("p32_done", {done, err, nes_rst, busy}, 4'b1000);

    // bytes after DONE are refused
    in_data = 8'hAA; in_valid = 1'b1;
    repeat (4) @(negedge clk_sys);
    in_valid = 1'b0;
    chk("after_done_ready", in_ready, 0);
    chk("after_done_writes", prg_n + chr_n, 32768 + 8192);

    // bad magic byte 3
    make_img(1'b0, 8'h1B, 8'h01);
    pulse_start();
    chk("restart_done_cleared", done, 0);
    send_img(4, 1'b0, ok);
    chk("magic_err", err, 1);
    chk("magic_ready", in_ready, 0);
    in_data = img[4]; in_valid = 1'b1;
    repeat (4) @(negedge clk_sys);
    in_valid = 1'b0;
    chk("magic_no_accept", in_ready, 0);
    chk("magic_writes", prg_n + chr_n, 0);
    chk("magic_nes_rst", nes_rst, 1);

    // mapper 1 in byte 6 rejected
    make_img(1'b1, 8'h1A, 8'h10);
    pulse_start();
    send_img(7, 1'b0, ok);
    chk("mapper_err", {err, busy}, 2'b10);

    // recovery with a 16K image and random valid gaps
    make_img(1'b1, 8'h1A, 8'h00);
    pulse_start();
    chk("recover_err_cleared", {err, busy}, 2'b01);
    send_img(16 + 16384 + 8192, 1'b1, ok);
    chk("p16_accept", ok, 1);
    repeat (3) @(negedge clk_sys);
    chk("p16_prg_n", prg_n, 16384);
    chk("p16_chr_n", chr_n, 8192);
    chk("p16_prg_at_chr", prg_at_chr, 16384);
    chk("p16_last_prg_a", last_prg_a, 15'h3FFF);
    chk("p16_bad", bad_n, 0);
    chk("p16_both", both_n, 0);
    chk("p16_flags", {mirror_v, prg_16k}, 2'b01);
    chk("p16_done", {done, err, nes_rst}, 3'b100);

    // reset mid-PRG, coinciding with an accepted byte
    make_img(1'b0, 8'h1A, 8'h01);
    pulse_start();
    send_img(16 + 100, 1'b0, ok);
    in_data = img[116]; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk_sys);
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_prg_we", prg_we, 0);
    chk("midrst_state", {busy, done, err, nes_rst}, 4'b0001);
    chk("midrst_flags", {mirror_v, prg_16k}, 0);
    chk("midrst_prg_a", prg_a, 0);
    @(negedge clk_sys);
    chk("midrst_prg_n", prg_n, 100);
    pulse_start();
    send_img(16 + 10, 1'b0, ok);
    repeat (2) @(negedge clk_sys);
    chk("reload_prg_n", prg_n, 10);
    chk("reload_bad", bad_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
